// File: rtl/mux_serial_accumulator.sv
// mux_serial_accumulator: channel-selected accumulator with a bit-serial single full-adder datapath
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   request to add the selected channel; in_ready: request can be accepted
//   sel        channel select, sampled on accept (sel >= CHANNELS adds 0 and flags sel_err)
//   data       flattened channels, channel k = data[k*WIDTH +: WIDTH]
//   clear      zero the accumulator while idle (wins over in_valid)
//   out_valid  result available; out_ready: consumer takes it
//   sum        accumulator value; carry: carry-out of the last add; sel_err: last sel was out of range
// Optional build macro MUX_ACC_SATURATE_EN: a carry-out saturates the accumulator to all-ones.
module mux_serial_accumulator #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS*WIDTH-1:0] data,
   input  logic                      clear,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          sum,
   output logic                      carry,
   output logic                      sel_err
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d, opd_q, opd_d, mux_val;
   logic [CW-1:0] cnt_q, cnt_d;
   logic cy_q, cy_d, err_q, err_d, hit, s, c_nxt;
   always_comb begin
      mux_val = '0;
      hit = 1'b0;
      for (int k = 0; k < CHANNELS; k++)
         if (sel == SEL_W'(k)) begin
            mux_val = data[k*WIDTH +: WIDTH];
            hit = 1'b1;
         end
   end
   assign s     = acc_q[0] ^ opd_q[0] ^ cy_q;
   assign c_nxt = (acc_q[0] & opd_q[0]) | (cy_q & (acc_q[0] ^ opd_q[0]));
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      opd_d     = opd_q;
      cnt_d     = cnt_q;
      cy_d      = cy_q;
      err_d     = err_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = !clear;
            if (clear) begin
               acc_d = '0;
               cy_d  = 1'b0;
               err_d = 1'b0;
            end else if (in_valid) begin
               opd_d   = mux_val;
               err_d   = !hit;
               cnt_d   = '0;
               cy_d    = 1'b0;
               state_d = ADD;
            end
         end
         ADD: begin
            // rotate right so the sum bit lands in the MSB; after WIDTH steps bit order is restored
            acc_d = {s, acc_q[WIDTH-1:1]};
            opd_d = opd_q >> 1;
            cy_d  = c_nxt;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d = DONE;
`ifdef MUX_ACC_SATURATE_EN
               if (c_nxt) acc_d = '1;
`endif
            end
         end
         DONE: begin
            out_valid = 1'b1;
            state_d = out_ready ? IDLE : DONE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         opd_q   <= '0;
         cnt_q   <= '0;
         cy_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         opd_q   <= opd_d;
         cnt_q   <= cnt_d;
         cy_q    <= cy_d;
         err_q   <= err_d;
      end
   end
   assign sum     = acc_q;
   assign carry   = cy_q;
   assign sel_err = err_q;
endmodule

// File: tb/tb_mux_serial_accumulator.sv
// tb_mux_serial_accumulator: directed self-checking bench for mux_serial_accumulator
module tb_mux_serial_accumulator;
   logic clk, rst;
   logic in_valid, in_ready, clear, out_valid, out_ready, carry, sel_err;
   logic [1:0] sel;
   logic [31:0] data;
   logic [7:0] sum;
   logic in_valid3, in_ready3, clear3, out_valid3, out_ready3, carry3, sel_err3;
   logic [1:0] sel3;
   logic [23:0] data3;
   logic [7:0] sum3;
   int vecs, errs;
`ifdef MUX_ACC_SATURATE_EN
   localparam logic [7:0] WRAP_SUM = 8'hFF;
`else
   localparam logic [7:0] WRAP_SUM = 8'h10;
`endif

   mux_serial_accumulator #(.WIDTH(8), .CHANNELS(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .data(data),
      .clear(clear), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry),
      .sel_err(sel_err));

   mux_serial_accumulator #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .sel(sel3), .data(data3),
      .clear(clear3), .out_valid(out_valid3), .out_ready(out_ready3), .sum(sum3), .carry(carry3),
      .sel_err(sel_err3));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // lat counts edges from the edge that opened the accept cycle; DONE is expected 9 edges later
   task automatic do_add(input logic [1:0] s, output int lat);
      in_valid = 1'b1;
      sel = s;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic do_add3(input logic [1:0] s, output int lat);
      in_valid3 = 1'b1;
      sel3 = s;
      tick();
      in_valid3 = 1'b0;
      lat = 1;
      while (!out_valid3 && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      #12;
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      vecs++; if (sum !== 8'h00) begin errs++; $display("FAIL rst_sum: got %h want 00", sum); end
      vecs++; if (carry !== 1'b0) begin errs++; $display("FAIL rst_carry: got %b want 0", carry); end
      vecs++; if (sel_err !== 1'b0) begin errs++; $display("FAIL rst_sel_err: got %b want 0", sel_err); end
      @(negedge clk);
      rst = 1'b0;
      tick();
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_single_add();
      int lat;
      do_add(2'd2, lat);
      vecs++; if (lat !== 9) begin errs++; $display("FAIL add_latency: got %0d want 9", lat); end
      vecs++; if (sum !== 8'h33) begin errs++; $display("FAIL add_sum: got %h want 33", sum); end
      vecs++; if (carry !== 1'b0) begin errs++; $display("FAIL add_carry: got %b want 0", carry); end
      vecs++; if (sel_err !== 1'b0) begin errs++; $display("FAIL add_sel_err: got %b want 0", sel_err); end
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL add_done_in_ready: got %b want 0", in_ready); end
      tick();
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL add_release: got %b want 0", out_valid); end
   endtask

   task automatic test_accumulate();
      int lat;
      do_add(2'd3, lat);
      vecs++; if (sum !== 8'h77) begin errs++; $display("FAIL acc_sum: got %h want 77", sum); end
      tick();
      clear = 1'b1;
      in_valid = 1'b1;
      #1;
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL clear_in_ready: got %b want 0", in_ready); end
      tick();
      clear = 1'b0;
      in_valid = 1'b0;
      vecs++; if (sum !== 8'h00) begin errs++; $display("FAIL clear_sum: got %h want 00", sum); end
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL clear_no_accept: got %b want 0", out_valid); end
   endtask

   task automatic test_wrap();
      int lat;
      data[7:0] = 8'hF0;
      do_add(2'd0, lat);
      vecs++; if (sum !== 8'hF0) begin errs++; $display("FAIL wrap_preload: got %h want f0", sum); end
      tick();
      data[7:0] = 8'h20;
      do_add(2'd0, lat);
      vecs++; if (lat !== 9) begin errs++; $display("FAIL wrap_latency: got %0d want 9", lat); end
      vecs++; if (sum !== WRAP_SUM) begin errs++; $display("FAIL wrap_sum: got %h want %h", sum, WRAP_SUM); end
      vecs++; if (carry !== 1'b1) begin errs++; $display("FAIL wrap_carry: got %b want 1", carry); end
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_backpressure();
      int lat;
      out_ready = 1'b0;
      do_add(2'd1, lat);
      vecs++; if (lat !== 9) begin errs++; $display("FAIL bp_latency: got %0d want 9", lat); end
      clear = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
         vecs++; if (sum !== 8'h22 || carry !== 1'b0) begin errs++; $display("FAIL bp_hold[%0d]: got %h/%b want 22/0", i, sum, carry); end
         vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      end
      clear = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_release: got %b want 0", out_valid); end
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_idle_ready: got %b want 1", in_ready); end
      vecs++; if (sum !== 8'h22) begin errs++; $display("FAIL bp_sum_kept: got %h want 22", sum); end
   endtask

   task automatic test_bad_select();
      int lat;
      do_add3(2'd1, lat);
      vecs++; if (sum3 !== 8'h20 || sel_err3 !== 1'b0) begin errs++; $display("FAIL sel_ok: got %h/%b want 20/0", sum3, sel_err3); end
      tick();
      do_add3(2'd3, lat);
      vecs++; if (lat !== 9) begin errs++; $display("FAIL sel_bad_latency: got %0d want 9", lat); end
      vecs++; if (sum3 !== 8'h20) begin errs++; $display("FAIL sel_bad_sum: got %h want 20", sum3); end
      vecs++; if (sel_err3 !== 1'b1) begin errs++; $display("FAIL sel_bad_err: got %b want 1", sel_err3); end
      tick();
      do_add3(2'd0, lat);
      vecs++; if (sum3 !== 8'h30) begin errs++; $display("FAIL sel_recover_sum: got %h want 30", sum3); end
      vecs++; if (sel_err3 !== 1'b0) begin errs++; $display("FAIL sel_recover_err: got %b want 0", sel_err3); end
      tick();
   endtask

   task automatic test_reset_mid_add();
      in_valid = 1'b1;
      sel = 2'd3;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      vecs++; if (sum !== 8'h62) begin errs++; $display("FAIL mid_partial: got %h want 62", sum); end
      #2 rst = 1'b1;
      #1;
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
      vecs++; if (sum !== 8'h00) begin errs++; $display("FAIL mid_rst_sum: got %h want 00", sum); end
      vecs++; if (carry !== 1'b0 || sel_err !== 1'b0) begin errs++; $display("FAIL mid_rst_flags: got %b/%b want 0/0", carry, sel_err); end
      @(negedge clk);
      rst = 1'b0;
      tick();
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL mid_after_ready: got %b want 1", in_ready); end
      repeat (10) tick();
      vecs++; if (out_valid !== 1'b0 || sum !== 8'h00) begin errs++; $display("FAIL mid_after_idle: got %b/%h want 0/00", out_valid, sum); end
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      clk = 1'b0;
      rst = 1'b1;
      in_valid = 1'b0;
      sel = '0;
      clear = 1'b0;
      out_ready = 1'b1;
      data = {8'h44, 8'h33, 8'h22, 8'h11};
      in_valid3 = 1'b0;
      sel3 = '0;
      clear3 = 1'b0;
      out_ready3 = 1'b1;
      data3 = {8'h30, 8'h20, 8'h10};
      test_reset();
      test_single_add();
      test_accumulate();
      test_wrap();
      test_backpressure();
      test_bad_select();
      test_reset_mid_add();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/mux_serial_accumulator.md
Name: mux_serial_accumulator

Overview:
- Parametrised successor to the team's 2:1 mux and full-adder circuits.
- Each transaction selects one of CHANNELS input words through an N:1 mux and adds it to a running accumulator.
- The add is done bit-serially on a single full-adder cell with a registered carry, LSB first, one bit per clock.
- Used wherever a small area-cheap channel-selected accumulator is needed; input and output use valid/ready handshakes.

Parameters:
- WIDTH, 8, operand and accumulator width in bits (>=2).
- CHANNELS, 4, number of mux input channels (>=2).
- SEL_W, $clog2(CHANNELS), select width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request to add the selected channel.
- in_ready  output  1  block can accept a request this cycle.
- sel  input  SEL_W  channel select, sampled on accept.
- data  input  CHANNELS*WIDTH  flattened channels; channel k = data[k*WIDTH +: WIDTH], sampled on accept.
- clear  input  1  zero the accumulator (honoured in IDLE only).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  accumulator value; stable while out_valid=1.
- carry  output  1  carry-out of the last addition.
- sel_err  output  1  last accepted sel was >= CHANNELS.

Behaviour:
- Reset: one clock and asynchronous, active-high reset (rst), per the already-decided interface. Any rst assertion, including mid-ADD, immediately forces:
  - state=IDLE;
  - accumulator, operand shift register, bit counter and carry flop to 0;
  - out_valid=0, sum=0, carry=0, sel_err=0.
  - The interrupted transaction is lost.
- States:
  - IDLE: in_ready = !clear.
    - clear=1: accumulator<=0, carry<=0, sel_err<=0, no accept. clear takes priority over in_valid.
    - in_valid & in_ready: latch operand = selected channel, or 0 with sel_err<=1 if sel>=CHANNELS; bit counter<=0, carry<=0; go to ADD.
  - ADD: in_ready=0. Each cycle one full-adder step on accumulator bit0 and operand bit0 with the carry flop:
    - s = a^b^c; c' = a&b | c&(a^b).
    - Accumulator rotates right with s entering the MSB; operand shifts right; counter increments.
    - After exactly WIDTH ADD cycles go to DONE; the accumulator then holds the full new sum in normal bit order.
  - DONE: out_valid=1; sum=accumulator; carry=final carry flop. Hold all outputs until out_ready=1, then go to IDLE with out_valid=0 the next cycle.
- Latency: accept edge to out_valid high = WIDTH+1 clocks. Throughput: one add per WIDTH+2 clocks when out_ready is held high.
- Arithmetic: modulo 2^WIDTH. The sum wraps; carry=1 flags the wrap. The accumulator persists across transactions until clear or rst.
- Ignored inputs:
  - in_valid, sel and data are ignored outside IDLE.
  - clear outside IDLE is ignored, not queued.
  - out_ready in IDLE or ADD has no effect.

Optional Feature:
- Macro: MUX_ACC_SATURATE_EN.
- Defined: when the final carry=1, the result is saturated. On entry to DONE the accumulator is loaded with all-ones (2^WIDTH-1) and carry=1; this saturated value persists.
- Undefined: wrap-around as in Behaviour.
- Latency is identical in both builds.

Test Plan (WIDTH=8, CHANNELS=4):
- Reset, then one add: channels {0x11,0x22,0x33,0x44}, sel=2, out_ready=1 -> out_valid exactly 9 clocks after accept; sum=0x33, carry=0, sel_err=0.
- Accumulate: add sel=3 (0x44) after the previous test -> sum=0x77. Then clear in IDLE -> in_ready=0 that cycle and next sum=0x00.
- Wrap: accumulator=0xF0, add channel value 0x20 -> sum=0x10, carry=1. With MUX_ACC_SATURATE_EN defined -> sum=0xFF, carry=1.
- Backpressure: out_ready=0 for 5 clocks in DONE -> sum/carry/out_valid stable, in_ready=0. out_ready=1 -> IDLE next clock, in_ready=1.
- Bad select: CHANNELS=3 build, sel=3 -> sum unchanged, sel_err=1. Next valid select clears sel_err.
- Reset mid-ADD: assert rst at bit 4 of an add -> outputs 0 immediately (asynchronous). After release, accumulator=0 and in_ready=1.
